// File: rtl/apb_cmd_initiator.sv
// APB3 requester: accepts one valid/ready command at a time, runs it as a single
// APB transfer with optional wait-state timeout, and returns data/status on a response port.
module apb_cmd_initiator #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-3:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-3:0] PADDR,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
    localparam bit          TO_EN    = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-3:0]   paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    wait_cnt_d  = 16'd0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Completion is checked before the timeout so a late PREADY still wins.
                if (PREADY) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (TO_EN && (wait_cnt_q == TO_LIMIT)) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = sat_inc16(wait_cnt_q);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'd0;
            wait_cnt_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Directed bench for apb_cmd_initiator (ADDR_W=12, TIMEOUT=4); cycle-accurate checks
// of the APB phases, response fields, back-pressure, timeout and reset behaviour.
module tb_apb_cmd_initiator;

    localparam int ADDR_W = 12;
    localparam int TO     = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-3:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err, rsp_timeout;
    logic              PSEL, PENABLE, PWRITE;
    logic [ADDR_W-3:0] PADDR;
    logic [31:0]       PWDATA, PRDATA;
    logic              PREADY, PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    apb_cmd_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then settled for the new cycle and inputs may be set.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Runs one full transfer starting in IDLE; waits = PREADY-low ACCESS cycles before completion.
    task automatic xfer(input string tag, input logic wr, input logic [9:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic err_fin, input logic err_wait,
                        input logic [31:0] exp_rdata, input logic exp_err);
        check({tag, " c0 cmd_ready"}, cmd_ready, 1);
        check({tag, " c0 psel"}, PSEL, 0);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        tick();
        cmd_valid = 0; cmd_addr = 10'h155; cmd_wdata = 32'hA5A5A5A5;
        check({tag, " setup psel"}, PSEL, 1);
        check({tag, " setup penable"}, PENABLE, 0);
        check({tag, " setup cmd_ready"}, cmd_ready, 0);
        check({tag, " setup paddr"}, PADDR, addr);
        check({tag, " setup pwrite"}, PWRITE, wr);
        if (wr) check({tag, " setup pwdata"}, PWDATA, wd);
        // Inputs during SETUP must be ignored.
        PREADY = 1; PSLVERR = 1; PRDATA = 32'hDEADBEEF;
        for (int i = 0; i <= waits; i++) begin
            tick();
            check({tag, " access psel"}, PSEL, 1);
            check({tag, " access penable"}, PENABLE, 1);
            check({tag, " access paddr"}, PADDR, addr);
            check({tag, " access rsp_valid"}, rsp_valid, 0);
            if (wr) check({tag, " access pwdata"}, PWDATA, wd);
            if (i == waits) begin
                PREADY = 1; PRDATA = rd; PSLVERR = err_fin;
            end else begin
                PREADY = 0; PRDATA = 32'hBAD0BAD0; PSLVERR = err_wait;
            end
        end
        tick();
        PREADY = 0; PSLVERR = 0; PRDATA = 32'h0;
        check({tag, " resp rsp_valid"}, rsp_valid, 1);
        check({tag, " resp psel"}, PSEL, 0);
        check({tag, " resp penable"}, PENABLE, 0);
        check({tag, " resp rdata"}, rsp_rdata, exp_rdata);
        check({tag, " resp err"}, rsp_err, exp_err);
        check({tag, " resp timeout"}, rsp_timeout, 0);
        check({tag, " resp cmd_ready"}, cmd_ready, 0);
        tick();
        check({tag, " idle cmd_ready"}, cmd_ready, 1);
        check({tag, " idle rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1; PRDATA = '0; PREADY = 0; PSLVERR = 0;
        tick();
        tick();
        check("rst cmd_ready", cmd_ready, 1);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_err", rsp_err, 0);
        check("rst rsp_timeout", rsp_timeout, 0);
        check("rst rsp_rdata", rsp_rdata, 0);
        check("rst psel", PSEL, 0);
        check("rst penable", PENABLE, 0);
        check("rst pwrite", PWRITE, 0);
        check("rst paddr", PADDR, 0);
        check("rst pwdata", PWDATA, 0);
        PRESET = 0;
        tick();

        // Zero-wait write: rdata must be 0 even though PRDATA is non-zero.
        xfer("wr0", 1'b1, 10'h000, 32'h3, 0, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wr0 pwdata held", PWDATA, 32'h3);
        check("wr0 pwrite held", PWRITE, 1);
        // Read with 3 wait states.
        xfer("rd3", 1'b0, 10'h3F8, 32'h0, 3, 32'h50, 1'b0, 1'b0, 32'h50, 1'b0);
        check("rd3 paddr held", PADDR, 10'h3F8);
        // Error at completion, then error only during wait cycles.
        xfer("err", 1'b0, 10'h010, 32'h0, 0, 32'hCAFE0001, 1'b1, 1'b0, 32'hCAFE0001, 1'b1);
        xfer("errw", 1'b0, 10'h011, 32'h0, 2, 32'h00000077, 1'b0, 1'b1, 32'h77, 1'b0);
        // PREADY on the 5th ACCESS cycle (counter == TIMEOUT) completes normally.
        xfer("to_race", 1'b0, 10'h020, 32'h0, TO, 32'h0000ABCD, 1'b0, 1'b0, 32'hABCD, 1'b0);
        xfer("wr_big", 1'b1, 10'h2AA, 32'hFFFF0000, 1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Timeout abort: PREADY never rises; 5 ACCESS cycles, then RESP.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 10'h0C4;
        tick();
        cmd_valid = 0;
        PREADY = 0; PRDATA = 32'hFFFFFFFF; PSLVERR = 0;
        for (int i = 0; i <= TO; i++) begin
            tick();
            check("to access penable", PENABLE, 1);
            check("to access rsp_valid", rsp_valid, 0);
        end
        tick();
        check("to rsp_valid", rsp_valid, 1);
        check("to rsp_err", rsp_err, 1);
        check("to rsp_timeout", rsp_timeout, 1);
        check("to rsp_rdata", rsp_rdata, 0);
        check("to psel", PSEL, 0);
        check("to penable", PENABLE, 0);
        tick();
        check("to idle cmd_ready", cmd_ready, 1);

        // Back-pressure with a second command pending.
        rsp_ready = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 10'h101;
        tick();
        cmd_addr = 10'h202; cmd_write = 1; cmd_wdata = 32'h0BADF00D;
        PREADY = 1;
        tick();
        PRDATA = 32'h13572468; PSLVERR = 1;
        tick();
        PREADY = 0; PSLVERR = 0; PRDATA = 32'h0;
        for (int i = 0; i < 10; i++) begin
            check("bp rsp_valid", rsp_valid, 1);
            check("bp rdata", rsp_rdata, 32'h13572468);
            check("bp err", rsp_err, 1);
            check("bp timeout", rsp_timeout, 0);
            check("bp cmd_ready", cmd_ready, 0);
            check("bp psel", PSEL, 0);
            if (i == 9) rsp_ready = 1;
            tick();
        end
        check("bp idle rsp_valid", rsp_valid, 0);
        check("bp idle cmd_ready", cmd_ready, 1);
        check("bp idle psel", PSEL, 0);
        tick();
        cmd_valid = 0;
        check("bp2 psel", PSEL, 1);
        check("bp2 paddr", PADDR, 10'h202);
        check("bp2 pwdata", PWDATA, 32'h0BADF00D);
        PREADY = 1;
        tick();
        tick();
        PREADY = 0;
        check("bp2 rsp_valid", rsp_valid, 1);
        check("bp2 rdata", rsp_rdata, 0);
        check("bp2 err", rsp_err, 0);
        tick();

        // Reset asserted during ACCESS.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 10'h0F0;
        tick();
        cmd_valid = 0; PREADY = 0;
        tick();
        check("rstx access penable", PENABLE, 1);
        PRESET = 1;
        tick();
        PRESET = 0; PREADY = 1; PRDATA = 32'h55AA55AA;
        check("rstx psel", PSEL, 0);
        check("rstx penable", PENABLE, 0);
        check("rstx rsp_valid", rsp_valid, 0);
        check("rstx cmd_ready", cmd_ready, 1);
        check("rstx paddr", PADDR, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstx after rsp_valid", rsp_valid, 0);
            check("rstx after psel", PSEL, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_initiator.md
# apb_cmd_initiator

APB initiator (requester) that turns single-word commands from a simple valid/ready command port into APB3 transfers, and returns read data and error status on a valid/ready response port. It drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA side of the FPGA I/O register block and similar APB completers. It is intended for test sequencers and the debug-bridge path. It performs one outstanding transfer at a time and has a programmable wait-state timeout.

## Interface
Parameters:
- ADDR_W, 12, APB address width; PADDR carries bits [ADDR_W-1:2] (word addresses only).
- TIMEOUT, 255, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout; legal range 0..65535.

Ports:
- PCLK  in  1  single clock for all logic.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W-2  word address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR was sampled high, or the transfer timed out.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W-2  APB word address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready / wait-state insertion.
- PSLVERR  in  1  APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The state and all outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=1:
    - Capture PRDATA for reads (0 for writes) into rsp_rdata.
    - Capture PSLVERR into rsp_err; rsp_timeout=0.
    - Go to RESP.
  - PREADY=0: increment the 16-bit wait counter.
  - When the wait counter equals TIMEOUT (TIMEOUT≠0) and PREADY=0:
    - Set rsp_rdata=0, rsp_err=1, rsp_timeout=1.
    - Go to RESP.
    - This abort drops PSEL/PENABLE mid-transfer by design; it is used for bus-hang recovery only.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - rsp_rdata/rsp_err/rsp_timeout are held stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE.
- PADDR/PWRITE/PWDATA hold their last value outside a transfer, and are stable from SETUP through the last ACCESS cycle.
- The wait counter clears on entry to SETUP and saturates at 0xFFFF; it does not wrap.
- PSLVERR and PRDATA are ignored in every cycle except ACCESS with PREADY=1.
- Reset values:
  - state=IDLE, cmd_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Reset asserted in any state takes effect on the next PCLK edge:
  - the transfer is abandoned;
  - no response is produced;
  - PSEL/PENABLE are low in the following cycle.

## Timing
- Cycle numbering for a zero-wait transfer:
  - Cycle 0: IDLE, cmd accepted (cmd_valid & cmd_ready).
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, PREADY=1.
  - Cycle 3: RESP, rsp_valid=1.
- Each PREADY-low cycle adds one ACCESS cycle.
- With rsp_ready held high, the minimum command-to-command period is 4 cycles (RESP→IDLE→accept).
- cmd_ready falls in the cycle after acceptance and rises again the cycle after the response handshake.
- Timeout with TIMEOUT=N: rsp_valid asserts N+1 cycles after the first ACCESS cycle, i.e. after N PREADY-low cycles.
- PREADY=1 in the same cycle the counter reaches TIMEOUT: the normal completion wins and rsp_timeout=0.
- rsp_valid does not depend combinationally on rsp_ready; cmd_ready does not depend combinationally on cmd_valid.

## Test plan
- Zero-wait write:
  - Stimulus: cmd write addr 0x000, data 0x3, PREADY=1.
  - Required response: PSEL high in cycles 1–2, PENABLE high in cycle 2 only, PWDATA=0x3, rsp_valid in cycle 3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: read addr 0x3F8; PREADY low for 3 ACCESS cycles, then high with PRDATA=0x50.
  - Required response: rsp_rdata=0x50, rsp_valid in cycle 6, PADDR stable throughout.
- Error:
  - Stimulus: read with PSLVERR=1 in the completing cycle.
  - Required response: rsp_err=1, rsp_timeout=0.
  - Also required: PSLVERR=1 during the PREADY=0 cycles only (low at completion) → rsp_err=0.
- Timeout:
  - Stimulus: TIMEOUT=4, PREADY held 0.
  - Required response: abort after 4 wait cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0.
  - Repeat with PREADY=1 on the 5th ACCESS cycle → normal completion.
- Back-pressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles with a second cmd_valid pending.
  - Required response: response fields stable, cmd_ready=0, no new PSEL until the response handshake.
- Reset mid-transfer:
  - Stimulus: assert PRESET in ACCESS.
  - Required response: PSEL/PENABLE/rsp_valid low in the next cycle, cmd_ready=1, and no response emitted after reset release.
